// File: rtl/bus_pkg.sv
// Shared definitions for the bus router: FSM state, device IDs, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

   // Router transaction phases
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Device IDs as decoded from the address select field
   localparam logic [3:0] DRAM = 4'd0;
   localparam logic [3:0] DROM = 4'd1;
   localparam logic [3:0] DMAT = 4'd2;
   localparam logic [3:0] DINT = 4'd3;
   localparam logic [3:0] DREG = 4'd4;
   localparam logic [3:0] DEXE = 4'd5;
   localparam logic [3:0] DSPI = 4'd6;
   localparam logic [3:0] DNON = 4'd7;

   // Default geometry of the core memory port
   localparam int BUS_ADDR_W  = 16;
   localparam int BUS_DATA_W  = 16;
   localparam int BUS_N_DEV   = 7;
   localparam int BUS_SEL_MSB = 15;
   localparam int BUS_SEL_LSB = 12;
   localparam int BUS_TIMEOUT = 16;

endpackage

// File: rtl/bus_timeout.sv
// BUSY-cycle watchdog: counts enabled cycles since clear, flags the last allowed one.
// Latency: expired is combinational from the count register.
// Backpressure: none; count freezes once expired until cleared.
module bus_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // expired marks the TIMEOUT-th cycle; an ack in that cycle still wins upstream
   assign expired = (cnt == CW'(TIMEOUT - 1));

   // Count enabled cycles, clear whenever the router is not waiting on a device
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/bus_router.sv
// Registered address decoder/router: one master transaction at a time to N_DEV devices.
// Latency: hit = ack cycle + 1 (min 2 after request); miss/illegal = 1 cycle.
// Backpressure: master holds request until m_ready; device stalls via d_ack.
// Optional device watchdog enabled by defining BUS_ROUTER_TIMEOUT_EN.
module bus_router
   import bus_pkg::*;
#(
   parameter int ADDR_W  = BUS_ADDR_W,
   parameter int DATA_W  = BUS_DATA_W,
   parameter int N_DEV   = BUS_N_DEV,
   parameter int SEL_MSB = BUS_SEL_MSB,
   parameter int SEL_LSB = BUS_SEL_LSB,
   parameter int TIMEOUT = BUS_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    m_rd,
   input  logic                    m_wr,
   input  logic [ADDR_W-1:0]       m_addr,
   input  logic [DATA_W-1:0]       m_wdata,
   output logic                    m_ready,
   output logic                    m_err,
   output logic [DATA_W-1:0]       m_rdata,
   output logic [N_DEV-1:0]        d_sel,
   output logic                    d_rd,
   output logic                    d_wr,
   output logic [ADDR_W-1:0]       d_addr,
   output logic [DATA_W-1:0]       d_wdata,
   input  logic [N_DEV*DATA_W-1:0] d_rdata,
   input  logic [N_DEV-1:0]        d_ack,
   output logic [7:0]              err_cnt
);

   localparam int IDW = SEL_MSB - SEL_LSB + 1;

   state_t              state;
   logic [IDW-1:0]      did_in;
   logic                hit_in;
   logic [N_DEV-1:0]    sel_in;
   logic                ack_hit;
   logic [DATA_W-1:0]   rdata_sel;
   logic                to_expired;

   // Decode the incoming request; only ever used to load registers
   assign did_in = m_addr[SEL_MSB:SEL_LSB];
   assign hit_in = int'(did_in) < N_DEV;
   assign sel_in = hit_in ? (N_DEV'(1) << did_in) : '0;

   // d_sel is one-hot while BUSY, so masking with it ignores other devices' acks
   assign ack_hit = |(d_ack & d_sel);

   // Pick the selected device's read slice using the registered one-hot select
   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < N_DEV; i++) begin
         if (d_sel[i]) begin
            rdata_sel = rdata_sel | d_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef BUS_ROUTER_TIMEOUT_EN
   bus_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state != BUSY),
      .en      ((state == BUSY) && !ack_hit),
      .expired (to_expired)
   );
`else
   assign to_expired = 1'b0;
`endif

   // Transaction FSM with all master/device outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         m_ready <= 1'b0;
         m_err   <= 1'b0;
         m_rdata <= '0;
         d_sel   <= '0;
         d_rd    <= 1'b0;
         d_wr    <= 1'b0;
         d_addr  <= '0;
         d_wdata <= '0;
         err_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m_rd || m_wr) begin
                  d_addr  <= m_addr;
                  d_wdata <= m_wdata;
                  if (m_rd && m_wr) begin
                     // Conflicting direction: answer with an error, never strobe a device
                     state   <= DONE;
                     m_ready <= 1'b1;
                     m_err   <= 1'b1;
                     m_rdata <= '0;
                  end else if (hit_in) begin
                     state <= BUSY;
                     d_sel <= sel_in;
                     d_rd  <= m_rd;
                     d_wr  <= m_wr;
                  end else begin
                     // Device ID beyond the populated range
                     state   <= DONE;
                     m_ready <= 1'b1;
                     m_err   <= 1'b1;
                     m_rdata <= '0;
                  end
               end
            end
            BUSY: begin
               if (ack_hit) begin
                  state   <= DONE;
                  m_ready <= 1'b1;
                  m_err   <= 1'b0;
                  m_rdata <= d_rd ? rdata_sel : '0;
                  d_sel   <= '0;
                  d_rd    <= 1'b0;
                  d_wr    <= 1'b0;
               end else if (to_expired) begin
                  // Device never answered: release it and report an error
                  state   <= DONE;
                  m_ready <= 1'b1;
                  m_err   <= 1'b1;
                  m_rdata <= '0;
                  d_sel   <= '0;
                  d_rd    <= 1'b0;
                  d_wr    <= 1'b0;
               end
            end
            DONE: begin
               state   <= IDLE;
               m_ready <= 1'b0;
               m_err   <= 1'b0;
               m_rdata <= '0;
               if (m_err && (err_cnt != 8'hFF)) begin
                  err_cnt <= err_cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_router.sv
// Self-checking bench for bus_router: directed and randomized transactions vs. a transaction-level model.
// Latency: checks exact cycle of m_ready for hits, misses, illegal requests and (optionally) timeouts.
// Backpressure: emulated devices ack after a chosen delay while unrelated devices toggle their acks.
module tb_bus_router;

   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         m_rd, m_wr;
   logic [15:0]  m_addr, m_wdata;
   logic         m_ready, m_err;
   logic [15:0]  m_rdata;
   logic [6:0]   d_sel;
   logic         d_rd, d_wr;
   logic [15:0]  d_addr, d_wdata;
   logic [111:0] d_rdata;
   logic [6:0]   d_ack;
   logic [7:0]   err_cnt;

   int tests = 0;
   int fails = 0;
   int err_model = 0;

   bus_router #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .N_DEV   (7),
      .SEL_MSB (15),
      .SEL_LSB (12),
      .TIMEOUT (TO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .m_rd    (m_rd),
      .m_wr    (m_wr),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_ready (m_ready),
      .m_err   (m_err),
      .m_rdata (m_rdata),
      .d_sel   (d_sel),
      .d_rd    (d_rd),
      .d_wr    (d_wr),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_ack   (d_ack),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_m_ready"}, 32'(m_ready), 0);
      check({tag, "_m_err"},   32'(m_err),   0);
      check({tag, "_m_rdata"}, 32'(m_rdata), 0);
      check({tag, "_d_sel"},   32'(d_sel),   0);
      check({tag, "_d_rd"},    32'(d_rd),    0);
      check({tag, "_d_wr"},    32'(d_wr),    0);
      check({tag, "_d_addr"},  32'(d_addr),  0);
      check({tag, "_d_wdata"}, 32'(d_wdata), 0);
      check({tag, "_err_cnt"}, 32'(err_cnt), 0);
   endtask

   // One complete transaction; k = BUSY cycle in which the target acks (0 = never)
   task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int k, input logic [15:0] data);
      logic [3:0] did;
      logic       hit, e;
      logic [6:0] oh, noise;
      int         lat, n;
      logic       seen, chk_rdata;
      logic [15:0] rexp;

      did = addr[15:12];
      hit = !(rd && wr) && (did < 4'd7);
      oh  = hit ? (7'b1 << did) : 7'b0;
      noise = 7'($urandom) & ~oh;
      chk_rdata = 1'b0;
      if (!hit) begin
         lat = 1; e = 1'b1;
`ifdef BUS_ROUTER_TIMEOUT_EN
      end else if (k == 0 || k > TO) begin
         lat = TO + 1; e = 1'b1; chk_rdata = rd;
`endif
      end else begin
         lat = k + 1; e = 1'b0; chk_rdata = rd;
      end
      rexp = (rd && !e) ? data : 16'h0;

      for (int i = 0; i < 7; i++) begin
         d_rdata[i*16 +: 16] = (hit && (i == int'(did))) ? data : 16'($urandom);
      end
      m_rd = rd; m_wr = wr; m_addr = addr; m_wdata = wdata; d_ack = 7'b0;

      n = 0; seen = 1'b0;
      while (!seen && n < 60) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (m_ready) begin
            seen = 1'b1;
         end else if (hit) begin
            check("busy_d_sel",   32'(d_sel),   32'(oh));
            check("busy_d_rd",    32'(d_rd),    32'(rd));
            check("busy_d_wr",    32'(d_wr),    32'(wr));
            check("busy_d_addr",  32'(d_addr),  32'(addr));
            check("busy_d_wdata", 32'(d_wdata), 32'(wdata));
            d_ack = (n == k) ? (noise | oh) : noise;
         end
      end
      check("ready_seen", 32'(seen), 1);
      check("latency", 32'(n), 32'(lat));
      check("m_err", 32'(m_err), 32'(e));
      if (chk_rdata) check("m_rdata", 32'(m_rdata), 32'(rexp));
      check("done_d_sel", 32'(d_sel), 0);
      check("done_strobe", 32'({d_rd, d_wr}), 0);

      m_rd = 1'b0; m_wr = 1'b0; d_ack = 7'b0;
      if (e) err_model = (err_model == 255) ? 255 : err_model + 1;
      @(posedge clk);
      @(negedge clk);
      check("ready_pulse", 32'(m_ready), 0);
      check("err_cnt", 32'(err_cnt), 32'(err_model));
   endtask

   initial begin
      logic        r, w;
      logic [15:0] a;
      int          wait_cycles;

      rst_n = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
      d_rdata = '0; d_ack = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases from the device map
      do_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 1, 16'hBEEF);
      do_txn(1'b0, 1'b1, 16'h6010, 16'hA5A5, 3, 16'h0000);
      do_txn(1'b1, 1'b0, 16'h8000, 16'h0000, 1, 16'h0000);
      do_txn(1'b1, 1'b1, 16'h0000, 16'h0000, 1, 16'h0000);
      check("err_cnt_two", 32'(err_cnt), 2);
`ifdef BUS_ROUTER_TIMEOUT_EN
      do_txn(1'b1, 1'b0, 16'h2000, 16'h0000, 0, 16'h1111);
      do_txn(1'b1, 1'b0, 16'h2000, 16'h0000, TO, 16'h2222);
      do_txn(1'b0, 1'b1, 16'h4000, 16'h3333, TO - 1, 16'h0000);
`endif

      // Randomized mix of hits, misses and illegal requests
      for (int t = 0; t < 40; t++) begin
         r = 1'($urandom);
         w = !r;
         if ($urandom_range(0, 9) == 0) begin r = 1'b1; w = 1'b1; end
         a = {4'($urandom_range(0, 8)), 12'($urandom)};
         do_txn(r, w, a, 16'($urandom), $urandom_range(1, 5), 16'($urandom));
      end

      // Long run of misses drives the error counter into saturation
      for (int t = 0; t < 300; t++) begin
         a = {4'($urandom_range(7, 15)), 12'($urandom)};
         do_txn(1'b1, 1'b0, a, 16'h0000, 1, 16'h0000);
      end
      check("err_cnt_sat", 32'(err_cnt), 255);

      // Foreign ack ignored while waiting on RAM, then reset drops the transaction
`ifdef BUS_ROUTER_TIMEOUT_EN
      wait_cycles = 10;
`else
      wait_cycles = 30;
`endif
      m_rd = 1'b1; m_addr = 16'h0042; m_wdata = 16'h0;
      @(posedge clk);
      @(negedge clk);
      d_ack = 7'b0001000;
      for (int c = 0; c < wait_cycles; c++) begin
         check("foreign_ack_ready", 32'(m_ready), 0);
         check("foreign_ack_sel", 32'(d_sel), 32'h1);
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      m_rd = 1'b0; d_ack = 7'b0;
      err_model = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("post_reset_ready", 32'(m_ready), 0);
      end
      do_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 2, 16'hC0DE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
